mul_error_stats: RTL and testbench
==================================

// Module: mul_error_stats
// PURPOSE
//  Downstream consumer of the 8-bit multiplier under evaluation (wallace/HPAM).
//  Accepts a stream of (a, b, result) triples and computes error metrics against the
//  exact product over a run of N samples: erroneous-sample count, max and summed error
//  distance (ED = |result - a*b|). Reports the totals once per run through a handshake.
// PARAMETERS
//  WIDTH  8               operand width; result/product width is 2*WIDTH
//  CNT_W  16              sample-counter width; max run length is 2**CNT_W-1
//  SUM_W  2*WIDTH+CNT_W   ED accumulator width; cannot overflow by construction
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high
//  start        in   1        begin a run; sampled only in IDLE
//  num_samples  in   CNT_W    run length; captured on start
//  busy         out  1        high in every state except IDLE
//  in_valid     in   1        sample valid
//  in_ready     out  1        sample accepted when in_valid && in_ready
//  in_a, in_b   in   WIDTH    multiplier operands
//  in_result    in   2*WIDTH  multiplier output under test
//  done_valid   out  1        statistics valid; held until done_ready
//  done_ready   in   1        statistics consumed
//  samples      out  CNT_W    samples accumulated this run
//  err_count    out  CNT_W    samples with result != a*b
//  max_ed       out  2*WIDTH  largest ED seen
//  sum_ed       out  SUM_W    sum of ED
//  sum_bias     out  SUM_W+1  signed sum of (result - a*b); see CONFIGURATION
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, pipeline valids 0. Applies in any state,
//    including mid-run; the partial run is discarded with no report.
//  - FSM: IDLE -start-> ACCUM (num_samples>0), or -start-> REPORT (num_samples==0).
//    ACCUM -> DRAIN on the edge that accepts the last sample.
//    DRAIN -> REPORT when both pipeline stages are empty. REPORT -done_ready-> IDLE.
//  - start is ignored outside IDLE. Accumulators clear on the start edge.
//  - in_ready = 1 only in ACCUM; combinational from state, not from in_valid.
//  - Pipeline: acceptance edge E0 captures a, b, result into stage 1. E1 registers the
//    exact product, ED and mismatch flag into stage 2. E2 adds stage 2 into the
//    accumulators. Back-to-back acceptance at 1 sample/cycle, no bubbles required.
//  - done_valid rises on the edge after the last accumulation: 3 edges after the
//    final accept, or 1 edge after start when num_samples==0. All stats = 0 in that case.
//  - In REPORT, stats and done_valid are stable until done_ready. done_valid drops
//    the edge done_ready is seen. A start in that same cycle is ignored.
//  - ED uses unsigned (2*WIDTH+1)-bit subtraction, then absolute value.
//    max_ed updates only when ED > max_ed.
//  - Operand 0 is legal: the exact product is 0. No division or relative error in RTL.
// CONFIGURATION
//  MUL_ERR_BIAS_EN defined: sum_bias accumulates the signed (result - exact) at E2.
//  Not defined: the bias logic is removed and sum_bias is tied to 0.
// STRUCTURE
//  Package mul_err_pkg: WIDTH/CNT_W defaults, the SUM_W function, and
//  typedef enum {IDLE, ACCUM, DRAIN, REPORT} mul_err_state_t.
//  Sub-module mul_err_calc: stage-2 register. Inputs are stage-1 a, b, result and valid.
//  Outputs are registered ED, mismatch flag, signed difference and valid.
//  The FSM, counters and accumulators live in the top module.
// TESTING
//  1 num_samples=3: (255,255,65025),(17,17,289),(23,67,1541)
//    -> samples=3, err_count=0, max_ed=0, sum_ed=0, sum_bias=0.
//  2 num_samples=3: (23,67,1540),(67,23,1545),(0,19,0)
//    -> err_count=2, max_ed=4, sum_ed=5; sum_bias=+3 with MUL_ERR_BIAS_EN, else 0.
//  3 num_samples=0, start pulse
//    -> done_valid high 1 edge later, all stats 0, in_ready never high.
//  4 in_valid gaps (1-on/2-off) over 4 samples, then done_ready held low 5 cycles
//    -> stats correct and stable, in_ready=0, extra start pulses ignored.
//  5 reset pulsed in ACCUM after 1 of 4 samples accepted
//    -> next cycle IDLE, all outputs 0; a following 2-sample run reports only its own data.
//  6 done_ready and start both high in REPORT
//    -> IDLE next edge, no new run; a start 1 cycle later begins a run normally.

Source files
------------

// File: rtl/mul_err_pkg.sv
// Shared parameters, accumulator width helper and FSM state type for the
// multiplier error-statistics block.
package mul_err_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // ED accumulator width: N <= 2**cnt_w-1 samples of ED < 2**(2*width).
    function automatic int sum_w(input int width, input int cnt_w);
        return 2 * width + cnt_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        REPORT
    } mul_err_state_t;

endpackage

// File: rtl/mul_error_stats_if.sv
// Run control, sample stream and statistics report for mul_error_stats.
// slave = the statistics block, master = whoever drives samples and consumes stats.
interface mul_error_stats_if
    import mul_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = sum_w(WIDTH, CNT_W)
) ();

    logic                      start;
    logic [CNT_W-1:0]          num_samples;
    logic                      busy;

    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_a;
    logic [WIDTH-1:0]          in_b;
    logic [2*WIDTH-1:0]        in_result;

    logic                      done_valid;
    logic                      done_ready;
    logic [CNT_W-1:0]          samples;
    logic [CNT_W-1:0]          err_count;
    logic [2*WIDTH-1:0]        max_ed;
    logic [SUM_W-1:0]          sum_ed;
    logic signed [SUM_W:0]     sum_bias;

    modport slave (
        input  start, num_samples, in_valid, in_a, in_b, in_result, done_ready,
        output busy, in_ready, done_valid, samples, err_count, max_ed, sum_ed, sum_bias
    );

    modport master (
        output start, num_samples, in_valid, in_a, in_b, in_result, done_ready,
        input  busy, in_ready, done_valid, samples, err_count, max_ed, sum_ed, sum_bias
    );

endinterface

// File: rtl/mul_err_calc.sv
// Stage-2 register: exact product, error distance, mismatch flag and, with
// MUL_ERR_BIAS_EN defined, the signed difference result - a*b.
module mul_err_calc
    import mul_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s1_valid,
    input  logic [WIDTH-1:0]        s1_a,
    input  logic [WIDTH-1:0]        s1_b,
    input  logic [2*WIDTH-1:0]      s1_result,
    output logic                    s2_valid,
    output logic [2*WIDTH-1:0]      s2_ed,
    output logic                    s2_mismatch
`ifdef MUL_ERR_BIAS_EN
    ,
    output logic signed [2*WIDTH:0] s2_diff
`endif
);

    logic [2*WIDTH-1:0] exact;
    logic [2*WIDTH:0]   diff;
    logic [2*WIDTH-1:0] ed;

    assign exact = (2*WIDTH)'(s1_a) * (2*WIDTH)'(s1_b);
    // One extra bit keeps the borrow, so the sign of result - exact is diff's MSB.
    assign diff  = {1'b0, s1_result} - {1'b0, exact};
    assign ed    = diff[2*WIDTH] ? (2*WIDTH)'(-diff) : diff[2*WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            s2_ed       <= '0;
            s2_mismatch <= 1'b0;
        end else begin
            s2_valid    <= s1_valid;
            s2_ed       <= ed;
            s2_mismatch <= (diff != '0);
        end
    end

`ifdef MUL_ERR_BIAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_diff <= '0;
        end else begin
            s2_diff <= $signed(diff);
        end
    end
`endif

endmodule

// File: rtl/mul_error_stats.sv
// Error statistics (error count, max/sum ED, optional signed bias) for a run of
// multiplier samples. Bias accumulation is built only with MUL_ERR_BIAS_EN defined.
//
//  state  | meaning
//  IDLE   | waiting for start; stats from the last run held
//  ACCUM  | accepting samples until num_samples have been taken
//  DRAIN  | all samples accepted; letting the two pipeline stages empty
//  REPORT | done_valid high, stats frozen until done_ready
module mul_error_stats
    import mul_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = sum_w(WIDTH, CNT_W)
) (
    input  logic              clk,
    input  logic              reset,
    mul_error_stats_if.slave  bus
);

    mul_err_state_t       state;
    logic [CNT_W-1:0]     remaining;
    logic                 accept;

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [2*WIDTH-1:0]   s1_result;

    logic                 s2_valid;
    logic [2*WIDTH-1:0]   s2_ed;
    logic                 s2_mismatch;

    logic                 done_valid;
    logic [CNT_W-1:0]     acc_samples;
    logic [CNT_W-1:0]     acc_err;
    logic [2*WIDTH-1:0]   acc_max;
    logic [SUM_W-1:0]     acc_sum;

    assign bus.in_ready = (state == ACCUM);
    assign bus.busy     = (state != IDLE);
    assign accept       = bus.in_valid && (state == ACCUM);

    assign bus.done_valid = done_valid;
    assign bus.samples    = acc_samples;
    assign bus.err_count  = acc_err;
    assign bus.max_ed     = acc_max;
    assign bus.sum_ed     = acc_sum;

`ifdef MUL_ERR_BIAS_EN
    logic signed [2*WIDTH:0] s2_diff;
    logic signed [SUM_W:0]   acc_bias;
`endif

    mul_err_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .clk         (clk),
        .reset       (reset),
        .s1_valid    (s1_valid),
        .s1_a        (s1_a),
        .s1_b        (s1_b),
        .s1_result   (s1_result),
        .s2_valid    (s2_valid),
        .s2_ed       (s2_ed),
        .s2_mismatch (s2_mismatch)
`ifdef MUL_ERR_BIAS_EN
        ,
        .s2_diff     (s2_diff)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_result   <= '0;
            done_valid  <= 1'b0;
            acc_samples <= '0;
            acc_err     <= '0;
            acc_max     <= '0;
            acc_sum     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a      <= bus.in_a;
                s1_b      <= bus.in_b;
                s1_result <= bus.in_result;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_samples <= '0;
                        acc_err     <= '0;
                        acc_max     <= '0;
                        acc_sum     <= '0;
                        remaining   <= bus.num_samples;
                        if (bus.num_samples == '0) begin
                            state      <= REPORT;
                            done_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state      <= REPORT;
                        done_valid <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.done_ready) begin
                        state      <= IDLE;
                        done_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stage 2 only holds data in ACCUM/DRAIN, so this never collides with the IDLE clear.
            if (s2_valid) begin
                acc_samples <= acc_samples + CNT_W'(1);
                acc_err     <= acc_err + CNT_W'(s2_mismatch);
                acc_sum     <= acc_sum + SUM_W'(s2_ed);
                if (s2_ed > acc_max) begin
                    acc_max <= s2_ed;
                end
            end
        end
    end

`ifdef MUL_ERR_BIAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_bias <= '0;
        end else if (state == IDLE && bus.start) begin
            acc_bias <= '0;
        end else if (s2_valid) begin
            acc_bias <= acc_bias + (SUM_W+1)'(s2_diff);
        end
    end

    assign bus.sum_bias = acc_bias;
`else
    assign bus.sum_bias = '0;
`endif

endmodule

// File: tb/tb_mul_error_stats.sv
// Self-checking bench for mul_error_stats: directed runs plus randomized runs
// compared against an arithmetic model of the error statistics.
module tb_mul_error_stats;
    import mul_err_pkg::*;

    localparam int W = 8;
    localparam int C = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_error_stats_if #(.WIDTH(W), .CNT_W(C)) bus ();

    mul_error_stats #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int va [32];
    int vb [32];
    int vr [32];
    int nsamp;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model(output longint e_err, output longint e_max,
                         output longint e_sum, output longint e_bias);
        longint d;
        e_err = 0; e_max = 0; e_sum = 0; e_bias = 0;
        for (int i = 0; i < nsamp; i++) begin
            d = longint'(vr[i]) - longint'(va[i]) * longint'(vb[i]);
            if (d != 0) e_err++;
            if (d < 0) d = -d;
            if (d > e_max) e_max = d;
            e_sum += d;
`ifdef MUL_ERR_BIAS_EN
            e_bias += longint'(vr[i]) - longint'(va[i]) * longint'(vb[i]);
`endif
        end
    endtask

    task automatic set_sample(input int i, input int a, input int b, input int r);
        va[i] = a; vb[i] = b; vr[i] = r;
    endtask

    task automatic feed(input string nm, input int gap);
        int w;
        int g;
        for (int i = 0; i < nsamp; i++) begin
            bus.in_a      = 8'(va[i]);
            bus.in_b      = 8'(vb[i]);
            bus.in_result = 16'(vr[i]);
            bus.in_valid  = 1'b1;
            w = 0;
            while (!bus.in_ready && w < 10) begin
                @(posedge clk); #1; w++;
            end
            chk({nm, ".rdy"}, longint'(bus.in_ready), 1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (i != nsamp - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) begin @(posedge clk); #1; end
            end
        end
    endtask

    // hold: cycles done_ready stays low in REPORT; poke: pulse start while holding;
    // start_on_ack: raise start together with done_ready.
    task automatic run(input string nm, input int gap, input int hold,
                       input bit poke, input bit start_on_ack);
        longint e_err, e_max, e_sum, e_bias;
        int k;
        model(e_err, e_max, e_sum, e_bias);
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.num_samples = 16'(nsamp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (nsamp == 0) begin
            k = 1;
        end else begin
            feed(nm, gap);
            k = 0;
        end
        while (!bus.done_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk({nm, ".latency"}, k, (nsamp == 0) ? 1 : 3);
        chk({nm, ".done_valid"}, longint'(bus.done_valid), 1);
        chk({nm, ".samples"}, longint'(bus.samples), nsamp);
        chk({nm, ".err_count"}, longint'(bus.err_count), e_err);
        chk({nm, ".max_ed"}, longint'(bus.max_ed), e_max);
        chk({nm, ".sum_ed"}, longint'(bus.sum_ed), e_sum);
        chk({nm, ".sum_bias"}, longint'($signed(bus.sum_bias)), e_bias);
        chk({nm, ".in_ready"}, longint'(bus.in_ready), 0);
        chk({nm, ".busy"}, longint'(bus.busy), 1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                bus.start = poke;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            chk({nm, ".hold_valid"}, longint'(bus.done_valid), 1);
            chk({nm, ".hold_err"}, longint'(bus.err_count), e_err);
            chk({nm, ".hold_sum"}, longint'(bus.sum_ed), e_sum);
            chk({nm, ".hold_ready"}, longint'(bus.in_ready), 0);
        end
        bus.done_ready = 1'b1;
        bus.start      = start_on_ack;
        @(posedge clk); #1;
        bus.done_ready = 1'b0;
        bus.start      = 1'b0;
        chk({nm, ".ack_valid"}, longint'(bus.done_valid), 0);
        chk({nm, ".ack_busy"}, longint'(bus.busy), 0);
    endtask

    task automatic rand_fill(input int n);
        int a, b, ex, r;
        nsamp = n;
        for (int i = 0; i < n; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            ex = a * b;
            case ($urandom_range(0, 3))
                0, 1: r = ex;
                2:    r = ex + int'($urandom_range(0, 16)) - 8;
                default: r = int'($urandom_range(0, 65535));
            endcase
            if (r < 0) r = 0;
            if (r > 65535) r = 65535;
            set_sample(i, a, b, r);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_result   = '0;
        bus.done_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst.busy", longint'(bus.busy), 0);
        chk("rst.in_ready", longint'(bus.in_ready), 0);
        chk("rst.done_valid", longint'(bus.done_valid), 0);
        chk("rst.sum_ed", longint'(bus.sum_ed), 0);

        // exact products, including the largest operands
        nsamp = 3;
        set_sample(0, 255, 255, 65025);
        set_sample(1, 17, 17, 289);
        set_sample(2, 23, 67, 1541);
        run("t1", 0, 0, 1'b0, 1'b0);

        // errors of both signs plus a zero operand
        nsamp = 3;
        set_sample(0, 23, 67, 1540);
        set_sample(1, 67, 23, 1545);
        set_sample(2, 0, 19, 0);
        run("t2", 0, 0, 1'b0, 1'b0);

        // empty run
        nsamp = 0;
        run("t3", 0, 0, 1'b0, 1'b0);

        // gapped input, held report, ignored start pulses
        nsamp = 4;
        set_sample(0, 200, 3, 601);
        set_sample(1, 12, 12, 100);
        set_sample(2, 255, 1, 255);
        set_sample(3, 9, 9, 81);
        run("t4", 2, 5, 1'b1, 1'b0);

        // reset mid-run discards the partial run
        nsamp = 4;
        set_sample(0, 100, 100, 0);
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.num_samples = 16'd4;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.in_a      = 8'd100;
        bus.in_b      = 8'd100;
        bus.in_result = 16'd0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5.busy", longint'(bus.busy), 0);
        chk("t5.in_ready", longint'(bus.in_ready), 0);
        chk("t5.done_valid", longint'(bus.done_valid), 0);
        chk("t5.samples", longint'(bus.samples), 0);
        chk("t5.err_count", longint'(bus.err_count), 0);
        chk("t5.max_ed", longint'(bus.max_ed), 0);
        chk("t5.sum_ed", longint'(bus.sum_ed), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5.idle_valid", longint'(bus.done_valid), 0);
        nsamp = 2;
        set_sample(0, 5, 6, 31);
        set_sample(1, 7, 8, 50);
        run("t5b", 0, 0, 1'b0, 1'b0);

        // start together with done_ready is ignored; the next start works
        nsamp = 1;
        set_sample(0, 3, 3, 10);
        run("t6", 0, 1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t6.still_idle", longint'(bus.busy), 0);
        nsamp = 2;
        set_sample(0, 128, 2, 200);
        set_sample(1, 44, 1, 44);
        run("t6b", 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rand_fill(int'($urandom_range(1, 12)));
            run($sformatf("rnd%0d", r), -1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
